multiply_acc_pipe: RTL and testbench

MULTIPLY_ACC_PIPE -- requirements
Module: multiply_acc_pipe

---
 rtl/multiply_acc_pkg.sv | 36 +++
 rtl/multiply_acc_stage.sv | 29 ++
 rtl/multiply_acc_pipe.sv | 156 +++++++++++++++
 tb/tb_multiply_acc_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_acc_pkg.sv
// Shared constants and saturation limit helpers for the multiply-accumulate pipeline.
package multiply_acc_pkg;

  localparam int unsigned DEF_A_WIDTH     = 16;
  localparam int unsigned DEF_B_WIDTH     = 16;
  localparam int unsigned DEF_ACC_GUARD   = 8;
  localparam int unsigned DEF_PIPE_STAGES = 3;

  // Limits are built at this width and truncated by the caller to ACC_WIDTH.
  localparam int unsigned LIMIT_WIDTH = 256;

  typedef logic [LIMIT_WIDTH-1:0] limit_t;

  // Largest value representable in w bits (two's complement when is_signed).
  function automatic limit_t sat_max(input int unsigned w, input bit is_signed);
    limit_t r;
    r = '0;
    for (int unsigned i = 0; i < LIMIT_WIDTH; i++) begin
      if (is_signed ? (i + 1 < w) : (i < w)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest value representable in w bits; sign-extended across LIMIT_WIDTH.
  function automatic limit_t sat_min(input int unsigned w, input bit is_signed);
    limit_t r;
    r = '0;
    if (is_signed) begin
      for (int unsigned i = 0; i < LIMIT_WIDTH; i++) begin
        if (i + 1 >= w) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multiply_acc_stage.sv
// One stall-aware register slice carrying a product, its clear flag and a valid bit.
module multiply_acc_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             in_valid,
  input  logic             in_clear,
  input  logic [WIDTH-1:0] in_prod,
  output logic             out_valid,
  output logic             out_clear,
  output logic [WIDTH-1:0] out_prod
);

  // Capture the upstream slot on advance; hold everything during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_clear <= 1'b0;
      out_prod  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_clear <= in_clear;
      out_prod  <= in_prod;
    end
  end

endmodule

// File: rtl/multiply_acc_pipe.sv
// Pipelined multiply-accumulate with valid/ready handshake and global stall.
// Define MULTIPLY_ACC_SAT_EN to saturate the accumulator and drive a sticky overflow flag;
// otherwise accumulation wraps and overflow is tied low.
module multiply_acc_pipe
  import multiply_acc_pkg::*;
#(
  parameter int unsigned A_WIDTH     = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH     = DEF_B_WIDTH,
  parameter int unsigned ACC_WIDTH   = A_WIDTH + B_WIDTH + DEF_ACC_GUARD,
  parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int unsigned SIGNED      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 overflow
);

  localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH;

  logic                  advance;
  logic [PROD_WIDTH-1:0] prod;
  logic [PROD_WIDTH-1:0] st_prod [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] st_valid;
  logic [PIPE_STAGES-1:0] st_clear;
  logic                  feed_valid;
  logic                  feed_clear;
  logic [PROD_WIDTH-1:0] feed_prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  acc;

  // A single advance moves every stage at once, so a held output freezes the whole pipe.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Full-width product; operands are pre-extended so the truncated result is exact.
  always_comb begin
    if (SIGNED != 0) begin
      prod = {{B_WIDTH{a[A_WIDTH-1]}}, a} * {{A_WIDTH{b[B_WIDTH-1]}}, b};
    end else begin
      prod = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
    end
  end

  assign st_prod[0]  = prod;
  assign st_valid[0] = in_valid;
  assign st_clear[0] = acc_clear;

  for (genvar g = 0; g < int'(PIPE_STAGES) - 1; g++) begin : g_stage
    multiply_acc_stage #(
      .WIDTH(PROD_WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .advance  (advance),
      .in_valid (st_valid[g]),
      .in_clear (st_clear[g]),
      .in_prod  (st_prod[g]),
      .out_valid(st_valid[g+1]),
      .out_clear(st_clear[g+1]),
      .out_prod (st_prod[g+1])
    );
  end

  assign feed_valid = st_valid[PIPE_STAGES-1];
  assign feed_clear = st_clear[PIPE_STAGES-1];
  assign feed_prod  = st_prod[PIPE_STAGES-1];

  // Extend the product to accumulator width in the selected signedness.
  always_comb begin
    if (SIGNED != 0) begin
      prod_ext = ACC_WIDTH'($signed(feed_prod));
    end else begin
      prod_ext = ACC_WIDTH'(feed_prod);
    end
  end

`ifdef MULTIPLY_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED != 0));

  logic [ACC_WIDTH:0] sum_wide;
  logic               sat_hit;
  logic               ovf;

  // Add with one guard bit and clamp when the true sum leaves the accumulator range.
  always_comb begin
    sum_wide = '0;
    sat_hit  = 1'b0;
    acc_sum  = acc + prod_ext;
    if (SIGNED != 0) begin
      sum_wide = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
      if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
        sat_hit = 1'b1;
        acc_sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
    end else begin
      sum_wide = {1'b0, acc} + {1'b0, prod_ext};
      if (sum_wide[ACC_WIDTH]) begin
        sat_hit = 1'b1;
        acc_sum = ACC_MAX;
      end
    end
  end

  // Sticky overflow; a clearing beat wins over a saturating sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (advance && feed_valid) begin
      if (feed_clear) begin
        ovf <= 1'b0;
      end else if (sat_hit) begin
        ovf <= 1'b1;
      end
    end
  end

  assign overflow = ovf;
`else
  // Wrapping accumulation modulo 2^ACC_WIDTH.
  always_comb begin
    acc_sum = acc + prod_ext;
  end

  assign overflow = 1'b0;
`endif

  // Next accumulator value for a valid beat entering the final stage.
  always_comb begin
    acc_next = feed_clear ? prod_ext : acc_sum;
  end

  // Accumulator stage: bubbles hold acc and drop out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= feed_valid;
      if (feed_valid) acc <= acc_next;
    end
  end

  assign out = acc;

endmodule

// File: tb/tb_multiply_acc_pipe.sv
// Self-checking bench for multiply_acc_pipe: directed vectors plus a queue-based
// running-sum model checked on every output transfer. Edge counting: "edge N" is the
// edge after which a beat is presented; it is captured at N+1 and seen after N+PIPE_STAGES.
module tb_multiply_acc_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        acc_clear;
  logic        out_ready;
  int          sel;
  bit          mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        iv0, iv1, iv2;
  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        ovf0, ovf1, ovf2;
  logic [39:0] out0, out1, out2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  multiply_acc_pipe u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(rdy0), .a(a), .b(b),
    .acc_clear(acc_clear), .out_valid(ov0), .out_ready(out_ready), .out(out0),
    .overflow(ovf0)
  );

  multiply_acc_pipe #(.SIGNED(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1), .a(a), .b(b),
    .acc_clear(acc_clear), .out_valid(ov1), .out_ready(out_ready), .out(out1),
    .overflow(ovf1)
  );

  multiply_acc_pipe #(.PIPE_STAGES(1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(rdy2), .a(a), .b(b),
    .acc_clear(acc_clear), .out_valid(ov2), .out_ready(out_ready), .out(out2),
    .overflow(ovf2)
  );

`ifdef MULTIPLY_ACC_SAT_EN
  logic        iv3, rdy3, ov3, ovf3;
  logic [31:0] out3;
  assign iv3 = in_valid && (sel == 3);

  multiply_acc_pipe #(.ACC_WIDTH(32)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy3), .a(a), .b(b),
    .acc_clear(acc_clear), .out_valid(ov3), .out_ready(out_ready), .out(out3),
    .overflow(ovf3)
  );
`endif

  logic        cur_rdy, cur_ov, cur_ovf;
  logic [39:0] cur_out;

  always_comb begin
    cur_rdy = rdy0;
    cur_ov  = ov0;
    cur_ovf = ovf0;
    cur_out = out0;
    case (sel)
      1: begin cur_rdy = rdy1; cur_ov = ov1; cur_ovf = ovf1; cur_out = out1; end
      2: begin cur_rdy = rdy2; cur_ov = ov2; cur_ovf = ovf2; cur_out = out2; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: running sum per accepted beat, queued in acceptance order.
  logic [39:0] exp_q[$];
  logic [39:0] acc_m = '0;
  logic [39:0] hold_val = '0;
  bit          hold_pend = 1'b0;
  int          acc_total = 0;

  always @(negedge clk) begin
    longint      pa, pb, pr;
    logic [39:0] e;
    if (reset) begin
      exp_q.delete();
      acc_m     = '0;
      hold_pend = 1'b0;
    end else if (mon_en && sel < 3) begin
      if (hold_pend) begin
        check("hold_valid", cur_ov, 1'b1);
        check("hold_out", cur_out, hold_val);
      end
      check("in_ready_rule", cur_rdy, !cur_ov || out_ready);
      if (cur_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out", cur_out, e);
        end
`ifndef MULTIPLY_ACC_SAT_EN
        check("overflow_tied", cur_ovf, 1'b0);
`endif
      end
      hold_pend = cur_ov && !out_ready;
      hold_val  = cur_out;
      if (in_valid && cur_rdy) begin
        pa = (sel == 1) ? longint'($signed(a)) : longint'(a);
        pb = (sel == 1) ? longint'($signed(b)) : longint'(b);
        pr = pa * pb;
        acc_m = acc_clear ? 40'(pr) : acc_m + 40'(pr);
        exp_q.push_back(acc_m);
        acc_total++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [15:0] av, input logic [15:0] bv,
                      input logic c);
    in_valid  = v;
    a         = av;
    b         = bv;
    acc_clear = c;
  endtask

  task automatic do_reset(input int s);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    sel = s;
    #1;
    check("rst_in_ready", cur_rdy, 1'b1);
    check("rst_out_valid", cur_ov, 1'b0);
    check("rst_out", cur_out, 40'd0);
    check("rst_overflow", cur_ovf, 1'b0);
    step();
    step();
    check("rst_hold_ready", cur_rdy, 1'b1);
    reset = 1'b0;
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_random(input int n, input bit with_stall);
    int target, cyc, t;
    bit stalled;
    target  = acc_total + n;
    cyc     = 0;
    stalled = 1'b0;
    while (acc_total < target && cyc < 5000) begin
      if (with_stall && !stalled && acc_total >= target - n / 2) begin
        stalled   = 1'b1;
        out_ready = 1'b1;
        beat(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        t = 0;
        while (!cur_ov && t < 10) begin
          step();
          t++;
        end
        check("stall_fill", cur_ov, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          step();
          check("stall_in_ready", cur_rdy, 1'b0);
          check("stall_out_valid", cur_ov, 1'b1);
        end
        out_ready = 1'b1;
      end
      beat($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      step();
      cyc++;
    end
    check("beats_accepted", acc_total >= target, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    acc_clear = 1'b0;
    out_ready = 1'b1;
    sel       = 0;
    step();
    do_reset(0);
    mon_en = 1'b1;

    // Default config: 3*4 clr, +5*6, +2*2 -> 12, 42, 46.
    beat(1'b1, 16'd3, 16'd4, 1'b1); step();
    beat(1'b1, 16'd5, 16'd6, 1'b0); step();
    beat(1'b1, 16'd2, 16'd2, 1'b0);
    check("lat_not_early", cur_ov, 1'b0);
    step();
    beat(1'b0, 16'd0, 16'd0, 1'b0);
    check("v1_valid", cur_ov, 1'b1);
    check("v1_out", cur_out, 40'd12);
    step();
    check("v2_out", cur_out, 40'd42);
    step();
    check("v3_out", cur_out, 40'd46);
    step();
    check("v_bubble", cur_ov, 1'b0);
    check("v_bubble_hold", cur_out, 40'd46);

    // Reset with two beats in flight; the next beat sums onto zero.
    beat(1'b1, 16'd100, 16'd100, 1'b1); step();
    beat(1'b1, 16'd50, 16'd50, 1'b0); step();
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_dropped", cur_ov, 1'b0);
    end
    beat(1'b1, 16'd7, 16'd7, 1'b0); step();
    beat(1'b0, 16'd0, 16'd0, 1'b0); step();
    step();
    check("rst_next_valid", cur_ov, 1'b1);
    check("rst_next_out", cur_out, 40'd49);
    step();

    // Random stream with a 5-cycle output stall mid-way.
    run_random(200, 1'b1);

    // Signed: -3*4 clr, +2*5 -> -12, -2.
    do_reset(1);
    beat(1'b1, 16'hFFFD, 16'd4, 1'b1); step();
    beat(1'b1, 16'd2, 16'd5, 1'b0); step();
    beat(1'b0, 16'd0, 16'd0, 1'b0); step();
    check("s1_out", cur_out, 40'hFF_FFFF_FFF4);
    step();
    check("s2_out", cur_out, 40'hFF_FFFF_FFFE);
    step();
    run_random(30, 1'b0);

    // Single-stage pipe: 9*9 clr visible one edge later.
    do_reset(2);
    beat(1'b1, 16'd9, 16'd9, 1'b1); step();
    beat(1'b0, 16'd0, 16'd0, 1'b0);
    check("p1_valid", cur_ov, 1'b1);
    check("p1_out", cur_out, 40'd81);
    step();
    check("p1_bubble", cur_ov, 1'b0);
    run_random(30, 1'b0);

`ifdef MULTIPLY_ACC_SAT_EN
    // Saturating 32-bit unsigned accumulator.
    do_reset(3);
    beat(1'b1, 16'hFFFF, 16'hFFFF, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 16'hFFFF, 16'hFFFF, 1'b0); step();
    end
    beat(1'b0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("sat_out", out3, 32'hFFFF_FFFF);
    check("sat_overflow", ovf3, 1'b1);
    beat(1'b1, 16'd1, 16'd1, 1'b1); step();
    beat(1'b0, 16'd0, 16'd0, 1'b0); step();
    step();
    check("sat_clr_valid", ov3, 1'b1);
    check("sat_clr_out", out3, 32'd1);
    check("sat_clr_overflow", ovf3, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
